// File: rtl/ps2_key_tracker.sv
// Tracks shift / caps-lock / num-lock state from PS/2 make/break events and
// queues non-modifier key presses, each with a modifier snapshot, in a FWFT FIFO.
module ps2_key_tracker #(
  parameter int DEPTH           = 8,
  parameter int REPEAT_SUPPRESS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_down,
  input  logic                     key_up,
  input  logic [7:0]               scan_code,
  output logic                     shift,
  output logic                     caps_lock,
  output logic                     num_lock,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_scan_code,
  output logic                     out_shift,
  output logic                     out_caps_lock,
  output logic                     out_num_lock,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CAPS   = 8'h58;
  localparam logic [7:0] CODE_NUM    = 8'h77;

  logic             lshift_held, rshift_held, caps_held, num_held;
  logic [7:0]       held_code;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [10:0]      mem [DEPTH];

  logic ev_valid, ev_down, ev_up, is_mod, press, repeat_hit;
  logic push_req, pop, full, push;
  logic [10:0] entry, head;

  // Both pulses in one cycle are treated as a release only.
  assign ev_valid   = (scan_code != 8'h00);
  assign ev_up      = key_up & ev_valid;
  assign ev_down    = key_down & ~key_up & ev_valid;
  assign is_mod     = (scan_code == CODE_LSHIFT) || (scan_code == CODE_RSHIFT) ||
                      (scan_code == CODE_CAPS)   || (scan_code == CODE_NUM);
  assign press      = ev_down & ~is_mod;
  assign repeat_hit = (REPEAT_SUPPRESS != 0) && (scan_code == held_code);
  assign push_req   = press & ~repeat_hit;

  assign shift     = lshift_held | rshift_held;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (count == DEPTH_C);
  assign push      = push_req & (~full | pop);
  assign entry     = {scan_code, shift, caps_lock, num_lock};

  assign head          = mem[rd_ptr];
  assign out_scan_code = head[10:3];
  assign out_shift     = head[2];
  assign out_caps_lock = head[1];
  assign out_num_lock  = head[0];

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lshift_held <= 1'b0;
      rshift_held <= 1'b0;
      caps_held   <= 1'b0;
      num_held    <= 1'b0;
      caps_lock   <= 1'b0;
      num_lock    <= 1'b0;
      held_code   <= 8'h00;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
    end else begin
      overflow <= push_req & full & ~pop;

      if (ev_down) begin
        case (scan_code)
          CODE_LSHIFT: lshift_held <= 1'b1;
          CODE_RSHIFT: rshift_held <= 1'b1;
          CODE_CAPS: begin
            if (!caps_held) caps_lock <= ~caps_lock;
            caps_held <= 1'b1;
          end
          CODE_NUM: begin
            if (!num_held) num_lock <= ~num_lock;
            num_held <= 1'b1;
          end
          default: if (push_req) held_code <= scan_code;
        endcase
      end

      if (ev_up) begin
        case (scan_code)
          CODE_LSHIFT: lshift_held <= 1'b0;
          CODE_RSHIFT: rshift_held <= 1'b0;
          CODE_CAPS:   caps_held   <= 1'b0;
          CODE_NUM:    num_held    <= 1'b0;
          default:     if (scan_code == held_code) held_code <= 8'h00;
        endcase
      end

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_ps2_key_tracker;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_down = 1'b0, key_up = 1'b0, out_ready = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       shift, caps_lock, num_lock, out_valid;
  logic [7:0] out_scan_code;
  logic       out_shift, out_caps_lock, out_num_lock, overflow;
  logic [3:0] count;

  ps2_key_tracker #(.DEPTH(DEPTH), .REPEAT_SUPPRESS(1)) dut (
    .clk(clk), .rst(rst), .key_down(key_down), .key_up(key_up),
    .scan_code(scan_code), .shift(shift), .caps_lock(caps_lock),
    .num_lock(num_lock), .out_valid(out_valid), .out_ready(out_ready),
    .out_scan_code(out_scan_code), .out_shift(out_shift),
    .out_caps_lock(out_caps_lock), .out_num_lock(out_num_lock),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: key state as plain flags, FIFO as a queue of {code,s,c,n}.
  bit         m_lsh, m_rsh, m_caps_h, m_num_h, m_caps, m_num, m_ovf;
  int         m_held;
  logic [10:0] m_q[$];

  function automatic void model_reset();
    m_lsh = 0; m_rsh = 0; m_caps_h = 0; m_num_h = 0;
    m_caps = 0; m_num = 0; m_ovf = 0; m_held = 0;
    m_q.delete();
  endfunction

  function automatic void model_step(input bit kd, input bit ku, input logic [7:0] sc, input bit rdy);
    bit          do_pop, do_push;
    logic [10:0] snap;
    do_pop  = (m_q.size() > 0) && rdy;
    do_push = 0;
    m_ovf   = 0;
    snap    = {sc, m_lsh | m_rsh, m_caps, m_num};
    if (sc != 0 && ku) begin
      if (sc == 8'h12) m_lsh = 0;
      else if (sc == 8'h59) m_rsh = 0;
      else if (sc == 8'h58) m_caps_h = 0;
      else if (sc == 8'h77) m_num_h = 0;
      else if (int'(sc) == m_held) m_held = 0;
    end else if (sc != 0 && kd) begin
      if (sc == 8'h12) m_lsh = 1;
      else if (sc == 8'h59) m_rsh = 1;
      else if (sc == 8'h58) begin
        if (!m_caps_h) m_caps = !m_caps;
        m_caps_h = 1;
      end else if (sc == 8'h77) begin
        if (!m_num_h) m_num = !m_num;
        m_num_h = 1;
      end else if (int'(sc) != m_held) begin
        m_held = int'(sc);
        if (m_q.size() < DEPTH || do_pop) do_push = 1;
        else m_ovf = 1;
      end
    end
    if (do_pop)  void'(m_q.pop_front());
    if (do_push) m_q.push_back(snap);
  endfunction

  task automatic check_all();
    check("shift", shift, m_lsh | m_rsh);
    check("caps_lock", caps_lock, m_caps);
    check("num_lock", num_lock, m_num);
    check("count", count, m_q.size());
    check("out_valid", out_valid, m_q.size() != 0);
    check("overflow", overflow, m_ovf);
    if (m_q.size() != 0)
      check("head", {out_scan_code, out_shift, out_caps_lock, out_num_lock}, m_q[0]);
  endtask

  task automatic cycle(input bit kd, input bit ku, input logic [7:0] sc, input bit rdy);
    key_down = kd; key_up = ku; scan_code = sc; out_ready = rdy;
    @(posedge clk);
    model_step(kd, ku, sc, rdy);
    #1;
    key_down = 0; key_up = 0; scan_code = 8'h00; out_ready = 0;
    check_all();
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_shift", shift, 0);
    check("rst_caps", caps_lock, 0);
    check("rst_num", num_lock, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk) rst = 1'b1;
  endtask

  logic [7:0] codes [10] = '{8'h12, 8'h59, 8'h58, 8'h77, 8'h1C, 8'h32, 8'h15, 8'h00, 8'h16, 8'h1D};

  initial begin
    int ovf_seen;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("init_count", count, 0);
    check("init_valid", out_valid, 0);
    check("init_ovf", overflow, 0);
    @(negedge clk) rst = 1'b1;

    // Reset then first press.
    cycle(1, 0, 8'h1C, 0);
    check("first_valid", out_valid, 1);
    check("first_entry", {out_scan_code, out_shift, out_caps_lock, out_num_lock}, {8'h1C, 3'b000});

    // Shift and caps snapshots.
    do_reset();
    cycle(1, 0, 8'h12, 0);
    cycle(1, 0, 8'h1C, 0);
    cycle(0, 1, 8'h12, 0);
    cycle(1, 0, 8'h58, 0);
    cycle(0, 1, 8'h58, 0);
    cycle(1, 0, 8'h32, 0);
    check("sc_count", count, 2);
    check("sc_caps", caps_lock, 1);
    check("sc_entry0", {out_scan_code, out_shift, out_caps_lock}, {8'h1C, 2'b10});
    cycle(0, 0, 8'h00, 1);
    check("sc_entry1", {out_scan_code, out_shift, out_caps_lock}, {8'h32, 2'b01});

    // Caps repeat.
    do_reset();
    repeat (3) cycle(1, 0, 8'h58, 0);
    check("crep_caps_on", caps_lock, 1);
    cycle(0, 1, 8'h58, 0);
    cycle(1, 0, 8'h58, 0);
    check("crep_caps_off", caps_lock, 0);
    check("crep_count", count, 0);

    // Repeat suppression.
    do_reset();
    repeat (4) cycle(1, 0, 8'h1C, 0);
    cycle(0, 1, 8'h1C, 0);
    cycle(1, 0, 8'h1C, 0);
    check("rsup_count", count, 2);
    check("rsup_head0", out_scan_code, 8'h1C);
    cycle(0, 0, 8'h00, 1);
    check("rsup_head1", out_scan_code, 8'h1C);

    // Overflow, then push while popping on a full FIFO.
    do_reset();
    ovf_seen = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(1, 0, 8'(8'h15 + i), 0);
      ovf_seen += int'(overflow);
    end
    cycle(0, 0, 8'h00, 0);
    ovf_seen += int'(overflow);
    check("ovf_count", count, 8);
    check("ovf_pulses", ovf_seen, 1);
    check("ovf_head", out_scan_code, 8'h15);
    cycle(1, 0, 8'h1E, 1);
    check("pushpop_count", count, 8);
    check("pushpop_ovf", overflow, 0);
    for (int i = 1; i < 8; i++) begin
      check("ovf_order", out_scan_code, 8'h15 + i);
      cycle(0, 0, 8'h00, 1);
    end
    check("ovf_last", out_scan_code, 8'h1E);

    // Both pulses high.
    do_reset();
    cycle(1, 1, 8'h12, 0);
    check("both_shift", shift, 0);

    // Random traffic against the model, with one asynchronous mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit kd, ku, rdy;
      logic [7:0] sc;
      r  = int'($urandom_range(0, 9));
      kd = (r < 4) || (r == 7);
      ku = (r >= 4 && r <= 7);
      sc = ($urandom_range(0, 15) == 0) ? 8'($urandom) : codes[$urandom_range(0, 9)];
      rdy = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      if (i == 1500) do_reset();
      cycle(kd, ku, sc, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
